// File: rtl/mig_rw_sched_if.sv
// Client and MIG-controller bundle for mig_rw_sched.
// slave: scheduler side; master: clients + controllers side.
interface mig_rw_sched_if #(
  parameter int ADDR_W = 28,
  parameter int LEN_W  = 16
);
  logic              wr_client_req;
  logic [LEN_W-1:0]  wr_client_len;
  logic              wr_client_ack;
  logic              wr_client_done;
  logic              rd_client_req;
  logic [LEN_W-1:0]  rd_client_len;
  logic              rd_client_ack;
  logic              rd_client_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [LEN_W-1:0]  wr_length;
  logic              wr_busy;
  logic              wr_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [LEN_W-1:0]  rd_length;
  logic              rd_busy;
  logic              rd_done;
  logic [LEN_W:0]    fill_level;
  logic              sched_busy;

  modport slave (
    input  wr_client_req, wr_client_len,
    input  rd_client_req, rd_client_len,
    input  wr_busy, wr_done, rd_busy, rd_done,
    output wr_client_ack, wr_client_done,
    output rd_client_ack, rd_client_done,
    output wr_req, wr_req_addr, wr_length,
    output rd_req, rd_req_addr, rd_length,
    output fill_level, sched_busy
  );

  modport master (
    output wr_client_req, wr_client_len,
    output rd_client_req, rd_client_len,
    output wr_busy, wr_done, rd_busy, rd_done,
    input  wr_client_ack, wr_client_done,
    input  rd_client_ack, rd_client_done,
    input  wr_req, wr_req_addr, wr_length,
    input  rd_req, rd_req_addr, rd_length,
    input  fill_level, sched_busy
  );
endinterface

// File: rtl/mig_rw_sched.sv
// Round-robin write/read burst scheduler over a circular DDR region.
// Ports: ui_clk, rst_n (async low), bus (mig_rw_sched_if.slave);
// init_calib_complete only with MIG_SCHED_CALIB_WAIT_EN defined.
module mig_rw_sched #(
  parameter int ADDR_W = 28,
  parameter int LEN_W  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int DEPTH_BEATS = 65536,
  parameter int STRIDE = 8
) (
  input logic ui_clk,
  input logic rst_n,
`ifdef MIG_SCHED_CALIB_WAIT_EN
  input logic init_calib_complete,
`endif
  mig_rw_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT
  } state_t;

  localparam logic [LEN_W+1:0] DEPTH =
    (LEN_W+2)'(DEPTH_BEATS);
  localparam logic [ADDR_W-1:0] REGION =
    ADDR_W'(DEPTH_BEATS * STRIDE);

  state_t state, state_n;
  logic last_rd;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [LEN_W:0] fill;
  logic [LEN_W+1:0] wr_sum;
  logic wr_ok, rd_ok, can_grant;
  logic gnt_wr, gnt_rd, wr_fin, rd_fin;

  // Bursts never straddle the end, so one subtract wraps.
  function automatic logic [ADDR_W-1:0] adv(
    input logic [ADDR_W-1:0] p,
    input logic [LEN_W-1:0] len
  );
    logic [ADDR_W-1:0] off;
    off = (p - BASE_ADDR)
        + ADDR_W'(len) * ADDR_W'(STRIDE);
    if (off >= REGION) off = off - REGION;
    return BASE_ADDR + off;
  endfunction

  assign bus.fill_level = fill;
  assign bus.sched_busy = (state != IDLE);

  always_comb begin
    wr_sum = (LEN_W+2)'(fill)
           + (LEN_W+2)'(bus.wr_client_len);
    wr_ok = bus.wr_client_req && (wr_sum <= DEPTH);
    rd_ok = bus.rd_client_req &&
      ((LEN_W+1)'(bus.rd_client_len) <= fill);
    // Ack-cycle block stops a zero-length client that is
    // still holding req from being granted twice.
    can_grant = !bus.wr_busy && !bus.rd_busy &&
      !bus.wr_client_ack && !bus.rd_client_ack;
`ifdef MIG_SCHED_CALIB_WAIT_EN
    can_grant = can_grant && init_calib_complete;
`endif
    gnt_wr  = 1'b0;
    gnt_rd  = 1'b0;
    wr_fin  = 1'b0;
    rd_fin  = 1'b0;
    state_n = state;
    unique case (state)
      IDLE: begin
        if (can_grant) begin
          if (wr_ok && (!rd_ok || last_rd)) gnt_wr = 1'b1;
          else if (rd_ok) gnt_rd = 1'b1;
          if (gnt_wr && bus.wr_client_len != '0)
            state_n = WR_ISSUE;
          if (gnt_rd && bus.rd_client_len != '0)
            state_n = RD_ISSUE;
        end
      end
      WR_ISSUE: state_n = WR_WAIT;
      WR_WAIT: if (bus.wr_done) begin
        wr_fin  = 1'b1;
        state_n = IDLE;
      end
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT: if (bus.rd_done) begin
        rd_fin  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      last_rd            <= 1'b1;
      wr_ptr             <= BASE_ADDR;
      rd_ptr             <= BASE_ADDR;
      fill               <= '0;
      bus.wr_client_ack  <= 1'b0;
      bus.rd_client_ack  <= 1'b0;
      bus.wr_client_done <= 1'b0;
      bus.rd_client_done <= 1'b0;
      bus.wr_req         <= 1'b0;
      bus.rd_req         <= 1'b0;
      bus.wr_req_addr    <= '0;
      bus.rd_req_addr    <= '0;
      bus.wr_length      <= '0;
      bus.rd_length      <= '0;
    end else begin
      state              <= state_n;
      bus.wr_client_ack  <= gnt_wr;
      bus.rd_client_ack  <= gnt_rd;
      bus.wr_client_done <= wr_fin ||
        (gnt_wr && bus.wr_client_len == '0);
      bus.rd_client_done <= rd_fin ||
        (gnt_rd && bus.rd_client_len == '0);
      bus.wr_req         <= (state == WR_ISSUE);
      bus.rd_req         <= (state == RD_ISSUE);
      if (gnt_wr) begin
        last_rd         <= 1'b0;
        bus.wr_length   <= bus.wr_client_len;
        bus.wr_req_addr <= wr_ptr;
      end
      if (gnt_rd) begin
        last_rd         <= 1'b1;
        bus.rd_length   <= bus.rd_client_len;
        bus.rd_req_addr <= rd_ptr;
      end
      if (wr_fin) begin
        wr_ptr <= adv(wr_ptr, bus.wr_length);
        fill   <= fill + (LEN_W+1)'(bus.wr_length);
      end
      if (rd_fin) begin
        rd_ptr <= adv(rd_ptr, bus.rd_length);
        fill   <= fill - (LEN_W+1)'(bus.rd_length);
      end
    end
  end

endmodule
